// File: rtl/move_commit_pkg.sv
// Shared piece encoding, promotion codes, FSM states and the standard start position.
package move_commit_pkg;
   localparam logic [3:0] EMPTY      = 4'h0;
   localparam logic [2:0] PAWN       = 3'd1;
   localparam logic [2:0] KNIGHT     = 3'd2;
   localparam logic [2:0] BISHOP     = 3'd3;
   localparam logic [2:0] ROOK       = 3'd4;
   localparam logic [2:0] QUEEN      = 3'd5;
   localparam logic [2:0] KING       = 3'd6;
   localparam int         COLOUR_BIT = 3;

   localparam logic [1:0] PROMO_Q = 2'b00;
   localparam logic [1:0] PROMO_R = 2'b01;
   localparam logic [1:0] PROMO_B = 2'b10;
   localparam logic [1:0] PROMO_N = 2'b11;

   typedef enum logic [2:0] {IDLE, PRECHK, WAIT, APPLY, REJECT} state_t;

   function automatic logic [2:0] back_rank(input int col);
      case (col)
         0, 7:    return ROOK;
         1, 6:    return KNIGHT;
         2, 5:    return BISHOP;
         3:       return QUEEN;
         default: return KING;
      endcase
   endfunction

   function automatic logic [2:0] promo_type(input logic [1:0] sel);
      case (sel)
         PROMO_Q: return QUEEN;
         PROMO_R: return ROOK;
         PROMO_B: return BISHOP;
         default: return KNIGHT;
      endcase
   endfunction

   // Black occupies rows 0/1, white rows 6/7; square s = col*8 + row.
   function automatic logic [255:0] std_board();
      logic [255:0] b;
      b = '0;
      for (int c = 0; c < 8; c++) begin
         b[4*(c*8+0) +: 4] = {1'b1, back_rank(c)};
         b[4*(c*8+1) +: 4] = {1'b1, PAWN};
         b[4*(c*8+6) +: 4] = {1'b0, PAWN};
         b[4*(c*8+7) +: 4] = {1'b0, back_rank(c)};
      end
      return b;
   endfunction

   localparam logic [255:0] INIT_BOARD = std_board();
endpackage

// File: rtl/board_writer.sv
// Combinational move application: clears the source square and places the piece on the
// target, promoting a pawn that lands on its last row.
module board_writer
   import move_commit_pkg::*;
(
   input  logic [255:0] board,
   input  logic [5:0]   src,
   input  logic [5:0]   tgt,
   input  logic [1:0]   promo,
   output logic [255:0] next_board
);
   logic [3:0] piece;
   logic [3:0] placed;
   logic       last_row;

   always_comb begin
      piece    = board[{src, 2'b00} +: 4];
      last_row = piece[COLOUR_BIT] ? (tgt[2:0] == 3'd7) : (tgt[2:0] == 3'd0);
      placed   = piece;
      if (piece[2:0] == PAWN && last_row)
         placed = {piece[COLOUR_BIT], promo_type(promo)};
      next_board = board;
      next_board[{src, 2'b00} +: 4] = EMPTY;
      next_board[{tgt, 2'b00} +: 4] = placed;
   end
endmodule

// File: rtl/move_commit.sv
// Board owner on the move-check path: latches a move, lets the checker judge it against
// the frozen board, then commits or refuses it with a one-cycle pulse.
module move_commit #(
   parameter int           CHECK_LATENCY = 2,
   parameter logic [255:0] INIT_BOARD    = move_commit_pkg::INIT_BOARD
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         new_game,
   input  logic         move_valid,
   output logic         move_ready,
   input  logic [13:0]  move_data,
   output logic [13:0]  chk_move_data,
   output logic [255:0] chk_board,
   input  logic         chk_allow,
   output logic [255:0] board_out,
   output logic         side_to_move,
   output logic         commit_pulse,
   output logic         reject_pulse
);
   import move_commit_pkg::*;

   localparam int CW = (CHECK_LATENCY > 1) ? $clog2(CHECK_LATENCY) : 1;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [255:0]  board;
   logic [255:0]  next_board;
   logic [5:0]    src;
   logic [5:0]    tgt;
   logic [3:0]    src_piece;

   assign src       = chk_move_data[11:6];
   assign tgt       = chk_move_data[5:0];
   assign src_piece = board[{src, 2'b00} +: 4];
   assign board_out = board;
   assign chk_board = board;

   board_writer u_writer (
      .board      (board),
      .src        (src),
      .tgt        (tgt),
      .promo      (chk_move_data[13:12]),
      .next_board (next_board)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         board         <= INIT_BOARD;
         side_to_move  <= 1'b0;
         chk_move_data <= '0;
         move_ready    <= 1'b1;
         commit_pulse  <= 1'b0;
         reject_pulse  <= 1'b0;
      end else begin
         commit_pulse <= 1'b0;
         reject_pulse <= 1'b0;
         case (state)
            IDLE: begin
               // new_game takes priority over a coincident move request
               if (new_game) begin
                  board        <= INIT_BOARD;
                  side_to_move <= 1'b0;
               end else if (move_valid) begin
                  chk_move_data <= move_data;
                  move_ready    <= 1'b0;
                  state         <= PRECHK;
               end
            end
            PRECHK: begin
               if (src_piece == EMPTY || src_piece[COLOUR_BIT] != side_to_move || src == tgt)
                  state <= REJECT;
               else begin
                  cnt   <= CW'(CHECK_LATENCY - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) state <= chk_allow ? APPLY : REJECT;
               else           cnt   <= cnt - 1'b1;
            end
            APPLY: begin
               board        <= next_board;
               side_to_move <= ~side_to_move;
               commit_pulse <= 1'b1;
               move_ready   <= 1'b1;
               state        <= IDLE;
            end
            REJECT: begin
               reject_pulse <= 1'b1;
               move_ready   <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               move_ready <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule
